regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the single-cycle core and its upcoming multi-cycle/pipelined variant.
- Provides NUM_RD combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- A per-register busy scoreboard tracks in-flight destination writes so that issue logic can detect RAW hazards.
- Sits between decode (read addresses, issue) and writeback (write port).

Parameters:
- XLEN, 32, data width of each register.
- DEPTH, 32, number of architectural registers (2..64).
- NUM_RD, 2, number of read ports (1..4).
- AW, 5, address width; must equal ceil(log2(DEPTH)).

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  packed read data; port i occupies bits [i*XLEN +: XLEN].
- rd_busy  out  NUM_RD  bit i set when read port i's register has a pending write.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback value.
- iss_en  in  1  issue strobe; marks iss_rd as pending.
- iss_rd  in  AW  destination of the issuing instruction.
- busy_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Reset:
  - Asynchronous: all registers = 0, all busy bits = 0, busy_cnt = 0.
  - rd_data follows the zeroed contents combinationally during reset.
  - Reset asserted mid-operation discards every pending busy bit and every register value immediately.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes to it and issues to it are ignored; busy_cnt is unaffected.
- Address range:
  - Addresses >= DEPTH read 0 with rd_busy = 0.
  - Writes and issues to addresses >= DEPTH are ignored.
- Read:
  - Combinational, zero latency: rd_data[i] = reg[rd_addr[i]], subject to the bypass rule under Optional Feature.
  - All ports are independent; any number of ports may read the same address.
- Write:
  - On posedge, when wr_en and wr_addr valid and nonzero: reg[wr_addr] <= wr_data.
  - Same posedge clears busy[wr_addr].
- Issue:
  - On posedge, when iss_en and iss_rd valid and nonzero: busy[iss_rd] <= 1.
  - Re-issuing an already-busy register keeps it busy; busy_cnt is unchanged.
- Simultaneous events, same posedge:
  - wr_addr == iss_rd (both nonzero): data is written AND the busy bit ends set (set wins; the newer producer owns the register). busy_cnt unchanged if it was already busy.
  - Different addresses: write clears one bit, issue sets the other; busy_cnt net change is -1, 0 or +1 accordingly.
  - wr_en to a non-busy register: the write is still performed; the busy bit stays 0.
- busy_cnt:
  - Registered; equals the popcount of busy bits after each posedge.
  - Never exceeds DEPTH-1.
- rd_busy[i] = busy[rd_addr[i]], subject to the bypass rule.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when wr_en is high and wr_addr == rd_addr[i] (nonzero, valid) in the same cycle:
  - rd_data[i] = wr_data, combinational write-to-read forwarding.
  - rd_busy[i] = 0, unless iss_en with iss_rd == rd_addr[i] in that same cycle.
- Undefined:
  - rd_data[i] shows the old stored value until after the posedge.
  - rd_busy[i] stays 1 for that cycle.

Test Plan:
- Reset then read: assert reset; read ports at addresses 0, 5, 31 -> rd_data all 0, rd_busy all 0, busy_cnt 0.
- Basic write/read:
  - Write 0xDEADBEEF to x7, then read x7 next cycle -> 0xDEADBEEF.
  - Write 0x12345678 to x0 -> x0 still reads 0.
- Scoreboard sequence:
  - Issue x3 -> rd_busy for x3 = 1 next cycle, busy_cnt 1.
  - Issue x4 -> busy_cnt 2.
  - Writeback x3 = 0x55 -> x3 not busy, reads 0x55, busy_cnt 1.
- Collision:
  - x9 busy; same cycle wr_en x9 = 0xA5A5A5A5 and iss_en x9 -> x9 reads 0xA5A5A5A5 and remains busy, busy_cnt unchanged.
  - Issue x0 -> busy_cnt unchanged.
- Bypass:
  - With REGFILE_BYPASS_EN, x2 = 0x1 busy; drive wr_en x2 = 0x2 and read x2 in the same cycle -> rd_data 0x2, rd_busy 0.
  - Without the macro -> rd_data 0x1, rd_busy 1; after the posedge -> 0x2, busy 0.
- Reset mid-operation: with x1 to x6 busy and nonzero, pulse reset between clock edges -> immediately all reads 0, busy_cnt 0; the following write to x1 works normally.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with NUM_RD combinational read ports, one write port and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int AW     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_busy_o,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [XLEN-1:0]        wr_data_i,
  input  logic                   iss_en_i,
  input  logic [AW-1:0]          iss_rd_i,
  output logic [AW:0]            busy_cnt_o
);

  logic [XLEN-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;
  logic             wr_ok_s, iss_ok_s;
  logic [AW-1:0]    ra_s;

  // Register 0 and out-of-range addresses are never writable, issuable or busy.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != {AW{1'b0}}) && (32'(a) < 32'(DEPTH));
  endfunction

  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] cnt;
    cnt = {(AW+1){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + {{AW{1'b0}}, v[k]};
    end
    return cnt;
  endfunction

  assign wr_ok_s    = wr_en_i && addr_ok(wr_addr_i);
  assign iss_ok_s   = iss_en_i && addr_ok(iss_rd_i);
  assign busy_cnt_o = busy_cnt_q;

  // Scoreboard next state: writeback clears first, issue sets afterwards so the newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok_s) begin
      busy_d[wr_addr_i] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (iss_ok_s) begin
      busy_d[iss_rd_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_cnt_d = popcount(busy_d);
  end

  // Combinational read ports, optionally forwarding the writeback in flight.
  always_comb begin
    rd_data_o = {(NUM_RD*XLEN){1'b0}};
    rd_busy_o = {NUM_RD{1'b0}};
    ra_s      = {AW{1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      ra_s = rd_addr_i[i*AW +: AW];
      if (addr_ok(ra_s)) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_ok_s && (wr_addr_i == ra_s)) begin
          rd_data_o[i*XLEN +: XLEN] = wr_data_i;
          rd_busy_o[i]              = iss_ok_s && (iss_rd_i == ra_s);
        end else begin
          rd_data_o[i*XLEN +: XLEN] = regs_q[ra_s];
          rd_busy_o[i]              = busy_q[ra_s];
        end
`else
        rd_data_o[i*XLEN +: XLEN] = regs_q[ra_s];
        rd_busy_o[i]              = busy_q[ra_s];
`endif
      end else begin
        rd_data_o[i*XLEN +: XLEN] = {XLEN{1'b0}};
        rd_busy_o[i]              = 1'b0;
      end
    end
  end

  // Architectural state and scoreboard; reset wipes everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= {XLEN{1'b0}};
      end
      busy_q     <= {DEPTH{1'b0}};
      busy_cnt_q <= {(AW+1){1'b0}};
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      if (wr_ok_s) begin
        regs_q[wr_addr_i] <= wr_data_i;
      end
    end
  end

endmodule
